calc_entry_ctrl: RTL and testbench
==================================

# calc_entry_ctrl

Sequencing controller for the calculator's operand-entry path. It steps the shared push-button digit counter through tens/ones of operand A, operator, and tens/ones of operand B. It captures each confirmed value, starts the arithmetic unit with a one-cycle handshake, and latches the result or error for display. It sits between the button edge detectors / digit counter and the ALU.

## Interface
- TIMEOUT, 255: maximum cycles to wait in CALC for `alu_done` before flagging an error (1..255).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_ok  in  1  single-cycle pulse: confirm current value.
- btn_clr  in  1  single-cycle pulse: abort and restart entry.
- digit_in  in  4  current value of the digit counter.
- alu_done  in  1  single-cycle pulse: ALU result valid.
- alu_result  in  14  ALU result, valid with `alu_done`.
- alu_err  in  1  ALU error (e.g. divide by zero), valid with `alu_done`.
- cnt_clr  out  1  one-cycle pulse that clears the digit counter.
- state_o  out  3  current state encoding, for display.
- a_val  out  7  operand A, range 0..99.
- b_val  out  7  operand B, range 0..99.
- op  out  2  operator: 0 add, 1 sub, 2 mul, 3 div.
- alu_start  out  1  one-cycle ALU start pulse.
- busy  out  1  high while in CALC.
- result_q  out  14  latched result.
- err  out  1  latched error flag.

## Operation
- **States and encoding:** A_TENS=0, A_ONES=1, OP_SEL=2, B_TENS=3, B_ONES=4, CALC=5, SHOW=6. Code 7 is illegal and goes to A_TENS on the next clock.
- **Reset (`reset`=0):** state A_TENS. All outputs 0, internal tens/ones digit registers 0, timeout counter 0.
- **Digit states (A_TENS, A_ONES, B_TENS, B_ONES):**
  - `btn_ok` with `digit_in` ≤ 9 captures the digit and advances to the next state.
  - `btn_ok` with `digit_in` > 9 is ignored: no state change, no `cnt_clr`.
- **Operand values:**
  - `a_val` updates on the A_ONES confirm to tens*10 + ones, computed in 7 bits (max 99).
  - `b_val` updates the same way on the B_ONES confirm.
  - Neither operand changes at any other time, except on clear or new entry.
- **OP_SEL:**
  - `btn_ok` with `digit_in` ≤ 3 sets `op` = `digit_in[1:0]` and advances to B_TENS.
  - Values 4..15 are ignored.
- **Counter clear:** every accepted confirm asserts `cnt_clr` for exactly one cycle, so the next field starts at 0.
- **CALC:**
  - `alu_start` is high only on the first cycle in CALC; `busy` is high for the whole state.
  - `a_val`, `b_val` and `op` are held stable throughout.
  - `alu_done` is sampled on every CALC cycle, including the start cycle. On `alu_done`, go to SHOW with `result_q` ← `alu_result` and `err` ← `alu_err`.
  - The timeout counter increments on each CALC cycle without `alu_done`. When it reaches TIMEOUT, go to SHOW with `err`=1 and `result_q`=0.
- **SHOW:**
  - `btn_ok` goes to A_TENS. It clears `a_val`, `b_val`, `op`, `result_q`, `err` and the digit registers, and pulses `cnt_clr`.
  - `digit_in` is ignored in SHOW.
- **`btn_clr`:**
  - From any state: go to A_TENS, clear all registers as on the SHOW→A_TENS transition, and pulse `cnt_clr`.
  - If `btn_clr` and `btn_ok` arrive in the same cycle, clear wins.
- **Ignored inputs:**
  - `alu_done` outside CALC is ignored, including a late done after a clear abort.
  - `btn_ok` in CALC is ignored.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Accepted `btn_ok` at edge N: the new state, captured value and `cnt_clr`=1 are all visible after edge N. `cnt_clr` drops after edge N+1.
- B_ONES confirm at edge N: state=CALC and `alu_start`=1 after N; `alu_start`=0 after N+1.
- `alu_done` at edge M: state=SHOW with `result_q`/`err` valid after M; `busy`=0 after M.
- Timeout: with no `alu_done`, state=SHOW exactly TIMEOUT cycles after entering CALC.
- The timeout counter resets to 0 on entering CALC.
- Asynchronous reset assertion forces all outputs to their reset values immediately, mid-operation included.
- Reset deassertion is used without an extra synchronizer stage here; the top level synchronizes it.

## Test plan
- **Reset:** assert `reset`=0 mid-CALC → immediately state_o=0, `alu_start`=0, `busy`=0, `a_val`=`b_val`=`result_q`=0, `err`=0.
- **Normal entry 12 + 34:** confirm digit_in 1,2,0,3,4 → one `cnt_clr` per confirm. Then `a_val`=12, `b_val`=34, `op`=0, and `alu_start` high exactly one cycle. `alu_done` with `alu_result`=46 three cycles later → state_o=6, `result_q`=46, `err`=0.
- **Rejects:**
  - `btn_ok` with `digit_in`=10 in A_TENS → state stays 0, no `cnt_clr`.
  - `btn_ok` with `digit_in`=5 in OP_SEL → state stays 2.
  - `digit_in`=3 → `op`=3, state_o=3.
- **Abort:** `btn_clr` in CALC → state_o=0 and `cnt_clr` pulse next cycle. A later `alu_done` (`alu_result`=99) leaves `result_q`=0.
- **Timeout:** TIMEOUT=8, no `alu_done` → state_o=6, `err`=1, `result_q`=0 exactly 8 cycles after CALC entry; `busy` falls on the same edge.
- **Priority:** `btn_ok` and `btn_clr` in the same cycle in B_ONES → state_o=0, `alu_start` never asserted, `a_val`=0.

Source files
------------

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: operand-entry sequencer for the calculator.
// It walks the digit counter through A tens/ones, the operator and B tens/ones.
// It then starts the ALU, waits for its result (with a timeout) and holds the
// result for display until the user confirms or clears.
module calc_entry_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_ok,
  input  logic        btn_clr,
  input  logic [3:0]  digit_in,
  input  logic        alu_done,
  input  logic [13:0] alu_result,
  input  logic        alu_err,
  output logic        cnt_clr,
  output logic [2:0]  state_o,
  output logic [6:0]  a_val,
  output logic [6:0]  b_val,
  output logic [1:0]  op,
  output logic        alu_start,
  output logic        busy,
  output logic [13:0] result_q,
  output logic        err
);

  typedef enum logic [2:0] {
    A_TENS = 3'd0,
    A_ONES = 3'd1,
    OP_SEL = 3'd2,
    B_TENS = 3'd3,
    B_ONES = 3'd4,
    CALC   = 3'd5,
    SHOW   = 3'd6
  } state_t;

  // Last counter value before the timeout fires; the counter starts at 0 on CALC entry.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  a_tens_q, a_tens_d;
  logic [3:0]  b_tens_q, b_tens_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [6:0]  a_val_d, b_val_d;
  logic [1:0]  op_d;
  logic [13:0] result_d;
  logic        err_d;
  logic        cnt_clr_d;
  logic        alu_start_d;
  logic        busy_d;
  logic        digit_ok;
  logic        op_ok;

  assign state_o = state_q;

  // Next-state and next-register computation; clear has priority over every confirm.
  always_comb begin
    state_d     = state_q;
    a_tens_d    = a_tens_q;
    b_tens_d    = b_tens_q;
    tmo_d       = tmo_q;
    a_val_d     = a_val;
    b_val_d     = b_val;
    op_d        = op;
    result_d    = result_q;
    err_d       = err;
    cnt_clr_d   = 1'b0;
    alu_start_d = 1'b0;
    digit_ok    = (digit_in <= 4'd9);
    op_ok       = (digit_in <= 4'd3);

    if (btn_clr) begin
      state_d   = A_TENS;
      a_tens_d  = '0;
      b_tens_d  = '0;
      tmo_d     = '0;
      a_val_d   = '0;
      b_val_d   = '0;
      op_d      = '0;
      result_d  = '0;
      err_d     = 1'b0;
      cnt_clr_d = 1'b1;
    end else begin
      case (state_q)
        A_TENS: begin
          if (btn_ok && digit_ok) begin
            a_tens_d  = digit_in;
            state_d   = A_ONES;
            cnt_clr_d = 1'b1;
          end
        end
        A_ONES: begin
          if (btn_ok && digit_ok) begin
            a_val_d   = ({3'b000, a_tens_q} * 7'd10) + {3'b000, digit_in};
            state_d   = OP_SEL;
            cnt_clr_d = 1'b1;
          end
        end
        OP_SEL: begin
          if (btn_ok && op_ok) begin
            op_d      = digit_in[1:0];
            state_d   = B_TENS;
            cnt_clr_d = 1'b1;
          end
        end
        B_TENS: begin
          if (btn_ok && digit_ok) begin
            b_tens_d  = digit_in;
            state_d   = B_ONES;
            cnt_clr_d = 1'b1;
          end
        end
        B_ONES: begin
          if (btn_ok && digit_ok) begin
            b_val_d     = ({3'b000, b_tens_q} * 7'd10) + {3'b000, digit_in};
            state_d     = CALC;
            cnt_clr_d   = 1'b1;
            alu_start_d = 1'b1;
            tmo_d       = '0;
          end
        end
        CALC: begin
          if (alu_done) begin
            result_d = alu_result;
            err_d    = alu_err;
            state_d  = SHOW;
          end else if (tmo_q == TMO_LAST) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = SHOW;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        SHOW: begin
          if (btn_ok) begin
            state_d   = A_TENS;
            a_tens_d  = '0;
            b_tens_d  = '0;
            tmo_d     = '0;
            a_val_d   = '0;
            b_val_d   = '0;
            op_d      = '0;
            result_d  = '0;
            err_d     = 1'b0;
            cnt_clr_d = 1'b1;
          end
        end
        default: begin
          // Illegal encoding: recover to a clean entry start.
          state_d  = A_TENS;
          a_tens_d = '0;
          b_tens_d = '0;
          tmo_d    = '0;
          a_val_d  = '0;
          b_val_d  = '0;
          op_d     = '0;
          result_d = '0;
          err_d    = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == CALC);
  end

  // State and all output registers; asynchronous active-low reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= A_TENS;
      a_tens_q  <= '0;
      b_tens_q  <= '0;
      tmo_q     <= '0;
      a_val     <= '0;
      b_val     <= '0;
      op        <= '0;
      result_q  <= '0;
      err       <= 1'b0;
      cnt_clr   <= 1'b0;
      alu_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_tens_q  <= a_tens_d;
      b_tens_q  <= b_tens_d;
      tmo_q     <= tmo_d;
      a_val     <= a_val_d;
      b_val     <= b_val_d;
      op        <= op_d;
      result_q  <= result_d;
      err       <= err_d;
      cnt_clr   <= cnt_clr_d;
      alu_start <= alu_start_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: directed, table-driven bench for calc_entry_ctrl with TIMEOUT=8.
module tb_calc_entry_ctrl;

  logic        clk;
  logic        reset;
  logic        btn_ok;
  logic        btn_clr;
  logic [3:0]  digit_in;
  logic        alu_done;
  logic [13:0] alu_result;
  logic        alu_err;
  logic        cnt_clr;
  logic [2:0]  state_o;
  logic [6:0]  a_val;
  logic [6:0]  b_val;
  logic [1:0]  op;
  logic        alu_start;
  logic        busy;
  logic [13:0] result_q;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ok;
    logic        clr;
    logic [3:0]  dig;
    logic        done;
    logic [13:0] res;
    logic        aerr;
    logic [2:0]  st;
    logic        cc;
    logic [6:0]  a;
    logic [6:0]  b;
    logic [1:0]  op;
    logic        start;
    logic        busy;
    logic [13:0] rq;
    logic        err;
  } vec_t;

  vec_t tbl [20];

  calc_entry_ctrl #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_ok     (btn_ok),
    .btn_clr    (btn_clr),
    .digit_in   (digit_in),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .cnt_clr    (cnt_clr),
    .state_o    (state_o),
    .a_val      (a_val),
    .b_val      (b_val),
    .op         (op),
    .alu_start  (alu_start),
    .busy       (busy),
    .result_q   (result_q),
    .err        (err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ok, input logic clr, input logic [3:0] dig,
                              input logic done, input logic [13:0] res, input logic aerr,
                              input logic [2:0] st, input logic cc, input logic [6:0] a,
                              input logic [6:0] b, input logic [1:0] o, input logic start,
                              input logic bsy, input logic [13:0] rq, input logic e);
    vec_t v;
    v.ok = ok; v.clr = clr; v.dig = dig; v.done = done; v.res = res; v.aerr = aerr;
    v.st = st; v.cc = cc; v.a = a; v.b = b; v.op = o; v.start = start;
    v.busy = bsy; v.rq = rq; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    chk({tag, " state_o"},   int'(state_o),   int'(v.st));
    chk({tag, " cnt_clr"},   int'(cnt_clr),   int'(v.cc));
    chk({tag, " a_val"},     int'(a_val),     int'(v.a));
    chk({tag, " b_val"},     int'(b_val),     int'(v.b));
    chk({tag, " op"},        int'(op),        int'(v.op));
    chk({tag, " alu_start"}, int'(alu_start), int'(v.start));
    chk({tag, " busy"},      int'(busy),      int'(v.busy));
    chk({tag, " result_q"},  int'(result_q),  int'(v.rq));
    chk({tag, " err"},       int'(err),       int'(v.err));
  endtask

  // Drive one vector across one rising edge, then check 1 ns after the edge.
  task automatic applyStimulus(input string tag, input vec_t v);
    btn_ok     = v.ok;
    btn_clr    = v.clr;
    digit_in   = v.dig;
    alu_done   = v.done;
    alu_result = v.res;
    alu_err    = v.aerr;
    @(posedge clk);
    #1;
    btn_ok   = 1'b0;
    btn_clr  = 1'b0;
    alu_done = 1'b0;
    checkOutput(tag, v);
  endtask

  // Walk 12 (+ op 0) 34 into CALC, checking each step.
  task automatic enterCalc(input string tag);
    applyStimulus({tag, " at"}, mk(1,0,1, 0,0,0, 1,1,  0, 0,0, 0,0, 0,0));
    applyStimulus({tag, " ao"}, mk(1,0,2, 0,0,0, 2,1, 12, 0,0, 0,0, 0,0));
    applyStimulus({tag, " op"}, mk(1,0,0, 0,0,0, 3,1, 12, 0,0, 0,0, 0,0));
    applyStimulus({tag, " bt"}, mk(1,0,3, 0,0,0, 4,1, 12, 0,0, 0,0, 0,0));
    applyStimulus({tag, " bo"}, mk(1,0,4, 0,0,0, 5,1, 12,34,0, 1,1, 0,0));
  endtask

  initial begin
    // Main table: normal 12+34 entry, rejects, done, then a 99 op3 0 entry into CALC.
    tbl[0]  = mk(1,0,10, 0, 0,0, 0,0,  0, 0,0, 0,0,  0,0);
    tbl[1]  = mk(1,0, 1, 0, 0,0, 1,1,  0, 0,0, 0,0,  0,0);
    tbl[2]  = mk(0,0, 1, 0, 0,0, 1,0,  0, 0,0, 0,0,  0,0);
    tbl[3]  = mk(1,0, 2, 0, 0,0, 2,1, 12, 0,0, 0,0,  0,0);
    tbl[4]  = mk(1,0, 5, 0, 0,0, 2,0, 12, 0,0, 0,0,  0,0);
    tbl[5]  = mk(1,0, 0, 0, 0,0, 3,1, 12, 0,0, 0,0,  0,0);
    tbl[6]  = mk(1,0, 3, 0, 0,0, 4,1, 12, 0,0, 0,0,  0,0);
    tbl[7]  = mk(1,0, 4, 0, 0,0, 5,1, 12,34,0, 1,1,  0,0);
    tbl[8]  = mk(0,0, 0, 0, 0,0, 5,0, 12,34,0, 0,1,  0,0);
    tbl[9]  = mk(1,0, 7, 0, 0,0, 5,0, 12,34,0, 0,1,  0,0);
    tbl[10] = mk(0,0, 0, 1,46,0, 6,0, 12,34,0, 0,0, 46,0);
    tbl[11] = mk(0,0, 0, 1,99,1, 6,0, 12,34,0, 0,0, 46,0);
    tbl[12] = mk(1,0, 9, 0, 0,0, 0,1,  0, 0,0, 0,0,  0,0);
    tbl[13] = mk(1,0, 9, 0, 0,0, 1,1,  0, 0,0, 0,0,  0,0);
    tbl[14] = mk(1,0, 9, 0, 0,0, 2,1, 99, 0,0, 0,0,  0,0);
    tbl[15] = mk(1,0, 3, 0, 0,0, 3,1, 99, 0,3, 0,0,  0,0);
    tbl[16] = mk(1,0, 0, 0, 0,0, 4,1, 99, 0,3, 0,0,  0,0);
    tbl[17] = mk(1,0,15, 0, 0,0, 4,0, 99, 0,3, 0,0,  0,0);
    tbl[18] = mk(1,0, 0, 0, 0,0, 5,1, 99, 0,3, 1,1,  0,0);
    tbl[19] = mk(0,0, 0, 0, 0,0, 5,0, 99, 0,3, 0,1,  0,0);

    reset      = 1'b0;
    btn_ok     = 1'b0;
    btn_clr    = 1'b0;
    digit_in   = 4'd0;
    alu_done   = 1'b0;
    alu_result = 14'd0;
    alu_err    = 1'b0;

    #12;
    checkOutput("reset", mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0, 0,0));
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus($sformatf("tbl[%0d]", i), tbl[i]);
    end

    // Timeout: CALC was entered at tbl[18]; tbl[19] was the 1st CALC edge, SHOW on the 8th.
    for (int k = 2; k <= 8; k++) begin
      if (k < 8)
        applyStimulus($sformatf("tmo%0d", k), mk(0,0,0, 0,0,0, 5,0, 99,0,3, 0,1, 0,0));
      else
        applyStimulus($sformatf("tmo%0d", k), mk(0,0,0, 0,0,0, 6,0, 99,0,3, 0,0, 0,1));
    end

    // Clear out of SHOW.
    applyStimulus("show_clr", mk(0,1,0, 0,0,0, 0,1, 0,0,0, 0,0, 0,0));

    // Abort from CALC, then a late done must be ignored.
    enterCalc("abort");
    applyStimulus("abort clr",  mk(0,1,0, 0, 0,0, 0,1, 0,0,0, 0,0, 0,0));
    applyStimulus("abort late", mk(0,0,0, 1,99,0, 0,0, 0,0,0, 0,0, 0,0));

    // Clear and confirm together in B_ONES: clear wins, ALU never started.
    applyStimulus("prio at", mk(1,0,1, 0,0,0, 1,1,  0,0,0, 0,0, 0,0));
    applyStimulus("prio ao", mk(1,0,2, 0,0,0, 2,1, 12,0,0, 0,0, 0,0));
    applyStimulus("prio op", mk(1,0,0, 0,0,0, 3,1, 12,0,0, 0,0, 0,0));
    applyStimulus("prio bt", mk(1,0,3, 0,0,0, 4,1, 12,0,0, 0,0, 0,0));
    applyStimulus("prio both", mk(1,1,4, 0,0,0, 0,1, 0,0,0, 0,0, 0,0));
    applyStimulus("prio idle", mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0, 0,0));

    // Asynchronous reset in the middle of CALC (alu_start still high).
    enterCalc("arst");
    #2 reset = 1'b0;
    #1;
    checkOutput("arst async", mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0, 0,0));
    #4 reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("arst after", mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0, 0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
